// File: rtl/fe25519_mul_serial.sv
// Bit-serial interleaved modular multiplier over GF(2^255-19).
// It processes one bit of the multiplier per clock, MSB first, using a
// double-and-add scheme with a conditional subtraction after each step.
// A start/valid/busy handshake connects it to the ladder controller.
module fe25519_mul_serial #(
  parameter int             W = 255,
  parameter logic [W-1:0]   P = {{(W-5){1'b1}}, 5'b01101}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] res,
  output logic         valid,
  output logic         busy
);

  localparam int         CW    = $clog2(W);
  localparam logic [W:0] P_EXT = {1'b0, P};

  typedef enum logic [1:0] {IDLE, PRERED, LOOP} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  ra_q, ra_d;
  logic [W-1:0]  rb_q, rb_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

  // Operand pre-reduction values. A single subtraction is enough because 2P exceeds 2^W.
  logic [W-1:0]  ra_red, rb_red;
  // Signals for one loop iteration. The doubled and summed values need one extra bit.
  logic [W:0]    dbl;
  logic [W-1:0]  dbl_red;
  logic [W:0]    sum;
  logic [W-1:0]  step_res;

  // Combinational logic for pre-reduction and one double-and-add iteration
  always_comb begin
    ra_red   = (ra_q >= P) ? ra_q - P : ra_q;
    rb_red   = (rb_q >= P) ? rb_q - P : rb_q;
    dbl      = {acc_q, 1'b0};
    dbl_red  = (dbl >= P_EXT) ? W'(dbl - P_EXT) : W'(dbl);
    sum      = rb_q[cnt_q] ? ({1'b0, dbl_red} + {1'b0, ra_q}) : {1'b0, dbl_red};
    step_res = (sum >= P_EXT) ? W'(sum - P_EXT) : W'(sum);
  end

  // Next-state and next-register logic for the control FSM
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          ra_d    = a;
          rb_d    = b;
          busy_d  = 1'b1;
          state_d = PRERED;
        end
      end
      PRERED: begin
        ra_d    = ra_red;
        rb_d    = rb_red;
        acc_d   = '0;
        cnt_d   = CW'(W - 1);
        state_d = LOOP;
      end
      LOOP: begin
        acc_d = step_res;
        if (cnt_q == '0) begin
          res_d   = step_res;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset is asynchronous and stops any operation in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign res   = res_q;
  assign valid = valid_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_fe25519_mul_serial.sv
// Scoreboard testbench for fe25519_mul_serial.
// Each accepted operation pushes its expected product and its issue cycle.
// The monitor pops the oldest entry on every valid pulse.
module tb_fe25519_mul_serial;

  localparam int           W = 255;
  localparam logic [W-1:0] P = {{(W-5){1'b1}}, 5'b01101};

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic [W-1:0] res;
  logic         valid, busy;

  fe25519_mul_serial #(.W(W), .P(P)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .res  (res),
    .valid(valid),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    int           t;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_valid  = 0;
  logic valid_prev = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference: compute the full product, then reduce it.
  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] pr;
    pr = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    pr = pr % {{W{1'b0}}, P};
    return pr[W-1:0];
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[W-33:0], 32'($urandom())};
    return r;
  endfunction

  // Monitor: on each valid pulse, compare the result with the scoreboard and check the handshake rules.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      n_valid++;
      $display("valid at cycle %0d res=%h", cyc, res);
      check("valid_not_busy", W'(busy), '0);
      check("res_lt_p", W'(res < P), W'(1));
      check("valid_single", W'(valid_prev), '0);
      if (sb.size() == 0) begin
        check("unexpected_valid", W'(1), '0);
      end else begin
        e = sb.pop_front();
        check("res", res, e.res);
        check("latency", W'(cyc - e.t), W'(W + 2));
      end
    end
    valid_prev = valid;
  end

  // Drive one accepted start (called at a negedge while idle). Returns at the next negedge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] exp);
    exp_t e;
    a     = x;
    b     = y;
    start = 1'b1;
    e.res = exp;
    e.t   = cyc;
    sb.push_back(e);
    $display("issue at cycle %0d a=%h b=%h", cyc, x, y);
    @(negedge clk);
    start = 1'b0;
    a     = rand_w();
    b     = rand_w();
    check("busy_after_accept", W'(busy), W'(1));
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", W'(busy), '0);
    @(negedge clk);
  endtask

  initial begin
    int bad;
    int k;
    logic [W-1:0] x, y;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_res", res, '0);
    check("reset_valid", W'(valid), '0);
    check("reset_busy", W'(busy), '0);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: 2*3. Check the busy window and the latency.
    issue(W'(2), W'(3), W'(6));
    bad = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (!busy || valid) bad++;
    end
    check("busy_window", W'(bad), '0);
    wait_done(10);

    // Test 2: boundary operands around P
    issue(P - 1, P - 1, W'(1));
    wait_done(400);
    issue(W'(121666), P - 1, P - W'(121666));
    wait_done(400);

    // Test 3: operands >= P and a zero multiplier
    issue({W{1'b1}}, W'(2), W'(36));
    wait_done(400);
    issue(P, W'(12345), '0);
    wait_done(400);
    issue(W'(5), '0, '0);
    wait_done(400);

    // Test 4: a start pulse while busy is ignored
    issue(W'(5), W'(7), W'(35));
    repeat (98) @(negedge clk);
    a = W'(9); b = W'(9); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400);

    // Test 5: reset in the middle of an operation. No valid pulse may follow.
    issue(W'(5), W'(7), W'(35));
    repeat (48) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    sb.delete();
    check("abort_res", res, '0);
    check("abort_busy", W'(busy), '0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    issue(W'(4), W'(4), W'(16));
    wait_done(400);

    // Test 6: start held high gives back-to-back operations
    begin
      exp_t e;
      a = W'(3); b = W'(4); start = 1'b1;
      e.res = W'(12); e.t = cyc; sb.push_back(e);
      @(negedge clk);
      a = P - 2; b = W'(2);
      k = 0;
      while (!valid && k < 400) begin
        @(negedge clk);
        k++;
      end
      check("b2b_timeout", W'(valid), W'(1));
      e.res = P - 4; e.t = cyc; sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", W'(busy), W'(1));
      wait_done(400);
    end

    // Random operands, checked against the reference model
    for (int n = 0; n < 200; n++) begin
      x = rand_w();
      y = rand_w();
      if (n % 8 == 1) x = P + W'($urandom_range(18, 0));
      if (n % 8 == 2) y = P - W'($urandom_range(5, 1));
      issue(x, y, ref_mul(x, y));
      wait_done(400);
    end

    check("sb_empty", W'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
